// File: rtl/prf_read_arbiter.sv
// Per-bank round-robin arbitration of operand-collector register reads onto the
// PRF bank read ports, with one-cycle response routing back to the winner.
module prf_read_arbiter #(
    parameter int REQUESTER_COUNT     = 4,
    parameter int LOG_REQUESTER_COUNT = $clog2(REQUESTER_COUNT),
    parameter int PRF_BANK_COUNT      = 4,
    parameter int LOG_PRF_BANK_COUNT  = $clog2(PRF_BANK_COUNT),
    parameter int PR_WIDTH            = 7
) (
    input  logic                                                 CLK,
    input  logic                                                 nRST,
    input  logic [REQUESTER_COUNT-1:0]                           req_valid_by_requester,
    input  logic [REQUESTER_COUNT-1:0][LOG_PRF_BANK_COUNT-1:0]   req_bank_by_requester,
    input  logic [REQUESTER_COUNT-1:0][PR_WIDTH-1:0]             req_pr_by_requester,
    output logic [REQUESTER_COUNT-1:0]                           req_ready_by_requester,
    output logic [PRF_BANK_COUNT-1:0]                            prf_read_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][PR_WIDTH-1:0]              prf_read_pr_by_bank,
    input  logic [PRF_BANK_COUNT-1:0]                            prf_read_ready_by_bank,
    input  logic [PRF_BANK_COUNT-1:0][31:0]                      prf_read_resp_data_by_bank,
    input  logic                                                 flush,
    output logic [REQUESTER_COUNT-1:0]                           reg_read_resp_valid_by_requester,
    output logic [REQUESTER_COUNT-1:0][31:0]                     reg_read_resp_data_by_requester
);

    localparam int IW = LOG_REQUESTER_COUNT;
    localparam logic [IW:0] RC_WIDE = (IW+1)'(REQUESTER_COUNT);

    logic [PRF_BANK_COUNT-1:0] bank_grant;
    logic [IW-1:0]             bank_grant_idx   [PRF_BANK_COUNT];
    logic [IW-1:0]             rr_ptr_reg       [PRF_BANK_COUNT];
    logic [IW-1:0]             rr_ptr_next      [PRF_BANK_COUNT];
    logic [PRF_BANK_COUNT-1:0] inflight_valid_reg;
    logic [IW-1:0]             inflight_req_reg [PRF_BANK_COUNT];

    genvar gi, gj;
    generate
        for (gi = 0; gi < PRF_BANK_COUNT; gi++) begin : g_bank
            logic [IW-1:0] cand_idx [REQUESTER_COUNT];
            logic          hit;
            logic [IW-1:0] hit_idx;

            // Candidate order: rr_ptr, rr_ptr+1, ... wrapping explicitly at REQUESTER_COUNT.
            for (gj = 0; gj < REQUESTER_COUNT; gj++) begin : g_off
                logic [IW:0] sum;
                logic [IW:0] sum_wrapped;
                assign sum         = {1'b0, rr_ptr_reg[gi]} + (IW+1)'(gj);
                assign sum_wrapped = sum - RC_WIDE;
                assign cand_idx[gj] = (sum >= RC_WIDE) ? sum_wrapped[IW-1:0] : sum[IW-1:0];
            end

            always_comb begin
                hit     = 1'b0;
                hit_idx = '0;
                for (int k = 0; k < REQUESTER_COUNT; k++) begin
                    if (!hit && req_valid_by_requester[cand_idx[k]] &&
                        req_bank_by_requester[cand_idx[k]] == LOG_PRF_BANK_COUNT'(gi)) begin
                        hit     = 1'b1;
                        hit_idx = cand_idx[k];
                    end
                end
            end

            assign bank_grant[gi]     = hit & prf_read_ready_by_bank[gi] & nRST;
            assign bank_grant_idx[gi] = hit_idx;
            assign rr_ptr_next[gi]    = (hit_idx == IW'(REQUESTER_COUNT-1)) ? '0 : hit_idx + 1'b1;

            assign prf_read_valid_by_bank[gi] = bank_grant[gi];
            assign prf_read_pr_by_bank[gi]    = bank_grant[gi] ? req_pr_by_requester[hit_idx] : '0;

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    rr_ptr_reg[gi]         <= '0;
                    inflight_valid_reg[gi] <= 1'b0;
                    inflight_req_reg[gi]   <= '0;
                end else begin
                    if (bank_grant[gi])
                        rr_ptr_reg[gi] <= rr_ptr_next[gi];
                    inflight_valid_reg[gi] <= bank_grant[gi] & ~flush;
                    inflight_req_reg[gi]   <= hit_idx;
                end
            end
        end

        for (gi = 0; gi < REQUESTER_COUNT; gi++) begin : g_req
            logic        ready_hit;
            logic        resp_hit;
            logic [31:0] resp_data;

            // Each requester targets one bank, so at most one bank matches here.
            always_comb begin
                ready_hit = 1'b0;
                resp_hit  = 1'b0;
                resp_data = '0;
                for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                    if (bank_grant[b] && bank_grant_idx[b] == IW'(gi))
                        ready_hit = 1'b1;
                    if (nRST && !flush && inflight_valid_reg[b] && inflight_req_reg[b] == IW'(gi)) begin
                        resp_hit  = 1'b1;
                        resp_data = prf_read_resp_data_by_bank[b];
                    end
                end
            end

            assign req_ready_by_requester[gi]           = ready_hit;
            assign reg_read_resp_valid_by_requester[gi] = resp_hit;
            assign reg_read_resp_data_by_requester[gi]  = resp_data;
        end
    endgenerate

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Bench for prf_read_arbiter: directed scenarios plus randomized traffic, all
// checked against a per-bank round-robin reference model.
module tb_prf_read_arbiter;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [3:0]        req_valid;
    logic [3:0][1:0]   req_bank;
    logic [3:0][6:0]   req_pr;
    logic [3:0]        req_ready;
    logic [3:0]        rd_valid;
    logic [3:0][6:0]   rd_pr;
    logic [3:0]        rd_ready;
    logic [3:0][31:0]  rd_data;
    logic              flush;
    logic [3:0]        resp_valid;
    logic [3:0][31:0]  resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_rr    [4];
    bit m_inf_v [4];
    int m_inf_r [4];
    // Expectations for the current cycle
    logic [3:0]       e_ready, e_pv, e_rv;
    logic [3:0][6:0]  e_pr;
    logic [3:0][31:0] e_rd;
    int               e_gidx [4];

    prf_read_arbiter dut (
        .CLK                              (CLK),
        .nRST                             (nRST),
        .req_valid_by_requester           (req_valid),
        .req_bank_by_requester            (req_bank),
        .req_pr_by_requester              (req_pr),
        .req_ready_by_requester           (req_ready),
        .prf_read_valid_by_bank           (rd_valid),
        .prf_read_pr_by_bank              (rd_pr),
        .prf_read_ready_by_bank           (rd_ready),
        .prf_read_resp_data_by_bank       (rd_data),
        .flush                            (flush),
        .reg_read_resp_valid_by_requester (resp_valid),
        .reg_read_resp_data_by_requester  (resp_data)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_rr[b] = 0; m_inf_v[b] = 0; m_inf_r[b] = 0;
        end
    endtask

    // Evaluate the model on the current inputs and compare every output.
    task automatic eval();
        #1;
        if (!nRST) model_reset();
        e_ready = '0; e_pv = '0; e_pr = '0; e_rv = '0; e_rd = '0;
        for (int b = 0; b < 4; b++) begin
            e_gidx[b] = -1;
            if (nRST && rd_ready[b]) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_rr[b] + k) % 4;
                    if (e_gidx[b] < 0 && req_valid[i] && req_bank[i] == b) e_gidx[b] = i;
                end
            end
            if (e_gidx[b] >= 0) begin
                e_pv[b] = 1'b1;
                e_pr[b] = req_pr[e_gidx[b]];
                e_ready[e_gidx[b]] = 1'b1;
            end
            if (nRST && !flush && m_inf_v[b]) begin
                e_rv[m_inf_r[b]] = 1'b1;
                e_rd[m_inf_r[b]] = rd_data[b];
            end
        end
        check("req_ready",  128'(req_ready),  128'(e_ready));
        check("rd_valid",   128'(rd_valid),   128'(e_pv));
        check("rd_pr",      128'(rd_pr),      128'(e_pr));
        check("resp_valid", 128'(resp_valid), 128'(e_rv));
        check("resp_data",  128'(resp_data),  128'(e_rd));
    endtask

    // Clock the model with the DUT, then return at the next falling edge.
    task automatic adv();
        @(posedge CLK);
        for (int b = 0; b < 4; b++) begin
            if (!nRST) begin
                m_rr[b] = 0; m_inf_v[b] = 0; m_inf_r[b] = 0;
            end else begin
                if (e_gidx[b] >= 0) m_rr[b] = (e_gidx[b] + 1) % 4;
                m_inf_v[b] = (e_gidx[b] >= 0) && !flush;
                m_inf_r[b] = (e_gidx[b] >= 0) ? e_gidx[b] : 0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_bank = '0; req_pr = '0;
        rd_ready = 4'hF; rd_data = '0; flush = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_seq [5];
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
        model_reset();
        nRST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        eval(); adv();
        nRST = 1'b1;

        // Single request to bank 2
        req_valid = 4'b0001; req_bank[0] = 2'd2; req_pr[0] = 7'h15;
        eval();
        check("single_ready", 128'(req_ready), 128'(4'b0001));
        check("single_pr", 128'(rd_pr[2]), 128'(7'h15));
        adv();
        idle_inputs(); rd_data[2] = 32'hDEADBEEF;
        eval();
        check("single_resp", 128'(resp_valid), 128'(4'b0001));
        check("single_data", 128'(resp_data[0]), 128'(32'hDEADBEEF));
        adv();

        // Round robin: everyone on bank 1
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'hF;
            for (int i = 0; i < 4; i++) begin req_bank[i] = 2'd1; req_pr[i] = 7'(i + 8); end
            rd_data = {4{$urandom}};
            eval();
            check("rr_grant", 128'(req_ready), 128'(rr_seq[c]));
            adv();
        end
        idle_inputs(); rd_data[1] = 32'h1111_0001;
        eval(); adv();

        // Parallel banks
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin req_bank[i] = 2'(i); req_pr[i] = 7'(i * 3 + 1); end
        eval();
        check("par_ready", 128'(req_ready), 128'(4'hF));
        adv();
        idle_inputs();
        for (int b = 0; b < 4; b++) rd_data[b] = 32'hA000_0000 + 32'(b);
        eval();
        check("par_resp", 128'(resp_valid), 128'(4'hF));
        adv();

        // Bank 3 stalled for three cycles, then grant
        idle_inputs();
        req_valid = 4'b0100; req_bank[2] = 2'd3; req_pr[2] = 7'h33; rd_ready[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            eval();
            check("stall_ready", 128'(req_ready), 128'(0));
            adv();
        end
        rd_ready[3] = 1'b1;
        eval();
        check("stall_grant", 128'(req_ready), 128'(4'b0100));
        adv();
        idle_inputs(); rd_data[3] = 32'h0BAD_F00D;
        eval(); adv();

        // Flush the cycle after a grant, then flush in the grant cycle
        req_valid = 4'b0010; req_bank[1] = 2'd0; req_pr[1] = 7'h41;
        eval(); adv();
        idle_inputs(); flush = 1'b1; rd_data[0] = 32'h1234_5678;
        eval();
        check("flush_resp", 128'(resp_valid), 128'(0));
        adv();
        req_valid = 4'b0010; req_bank[1] = 2'd0; flush = 1'b1;
        eval(); adv();
        idle_inputs(); rd_data[0] = 32'h8765_4321;
        eval();
        check("flush_grant_resp", 128'(resp_valid), 128'(0));
        adv();

        // Reset in the middle of an outstanding read
        req_valid = 4'b1000; req_bank[3] = 2'd1; req_pr[3] = 7'h7F;
        eval(); adv();
        nRST = 1'b0; req_valid = 4'hF; req_bank = '0; rd_data = {4{32'hFFFF_FFFF}};
        eval();
        check("rst_resp", 128'(resp_valid), 128'(0));
        adv();
        nRST = 1'b1;
        eval();
        check("rst_first_grant", 128'(req_ready), 128'(4'b0001));
        adv();

        // Randomized traffic with requester hold-until-ready
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || e_ready[i] || $urandom_range(7) == 0) begin
                    req_valid[i] = ($urandom_range(9) < 7);
                    req_bank[i]  = 2'($urandom_range(3));
                    req_pr[i]    = 7'($urandom);
                end
            end
            for (int b = 0; b < 4; b++) begin
                rd_ready[b] = ($urandom_range(9) < 8);
                rd_data[b]  = $urandom;
            end
            flush = ($urandom_range(9) == 0);
            nRST  = ($urandom_range(99) != 0);
            eval();
            adv();
            if (!nRST) begin
                nRST = 1'b1;
                e_ready = '0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prf_read_arbiter.md
Name: prf_read_arbiter

Overview:
- Shares the PRF bank read ports between REQUESTER_COUNT operand collectors.
- Each cycle, each requester presents at most one register read targeting one bank.
- Per bank, a round-robin arbiter grants one requester and drives that bank's read port.
- The PRF returns data exactly one cycle later; the block routes it back to the granted requester as reg_read_resp_valid/data, the operand collector's reg-read input.

Parameters:
- REQUESTER_COUNT, 4, number of operand collectors sharing the PRF
- LOG_REQUESTER_COUNT, $clog2(REQUESTER_COUNT), requester index width
- PRF_BANK_COUNT, 4, number of PRF banks, one read port each
- LOG_PRF_BANK_COUNT, $clog2(PRF_BANK_COUNT), bank index width
- PR_WIDTH, 7, physical register tag width

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- req_valid_by_requester  input  [REQUESTER_COUNT]  read request present
- req_bank_by_requester  input  [REQUESTER_COUNT][LOG_PRF_BANK_COUNT]  target bank
- req_pr_by_requester  input  [REQUESTER_COUNT][PR_WIDTH]  physical register tag
- req_ready_by_requester  output  [REQUESTER_COUNT]  request granted this cycle
- prf_read_valid_by_bank  output  [PRF_BANK_COUNT]  bank read port enable
- prf_read_pr_by_bank  output  [PRF_BANK_COUNT][PR_WIDTH]  tag sent to bank
- prf_read_ready_by_bank  input  [PRF_BANK_COUNT]  bank port available this cycle
- prf_read_resp_data_by_bank  input  [PRF_BANK_COUNT][32]  bank read data, one cycle after valid&ready
- flush  input  1  squash all in-flight responses
- reg_read_resp_valid_by_requester  output  [REQUESTER_COUNT]  response to requester
- reg_read_resp_data_by_requester  output  [REQUESTER_COUNT][32]  response data

Behaviour:
- State per bank b:
  - rr_ptr[b] (LOG_REQUESTER_COUNT bits), reset 0.
  - inflight_valid[b], reset 0.
  - inflight_req[b] (LOG_REQUESTER_COUNT bits), reset 0.
- Arbitration (combinational, cycle T):
  - Candidates for bank b are the requesters with req_valid=1 and req_bank=b.
  - Search starts at rr_ptr[b] and wraps modulo REQUESTER_COUNT; the first candidate wins.
  - Grant occurs only if prf_read_ready_by_bank[b]=1.
  - On grant to requester i: prf_read_valid_by_bank[b]=1, prf_read_pr_by_bank[b]=req_pr[i], req_ready[i]=1.
  - With no grant, prf_read_valid_by_bank[b]=0 and prf_read_pr_by_bank[b]=0.
  - req_ready is 0 for every non-granted requester. Each requester targets exactly one bank, so it receives at most one grant.
- Pointer update (posedge):
  - On grant to i at bank b, rr_ptr[b] <= (i+1) mod REQUESTER_COUNT.
  - With no grant (no candidates or bank not ready), rr_ptr[b] holds.
  - For non-power-of-2 REQUESTER_COUNT, the wrap returns explicitly to 0.
- Handshake: a requester holds its request (valid, bank, pr) stable until req_ready=1. Dropping valid early is legal and is not an error.
- Response pipeline (posedge):
  - inflight_valid[b] <= grant[b] & ~flush.
  - inflight_req[b] <= granted index.
- Response routing (combinational, cycle T+1):
  - reg_read_resp_valid[i] = OR over b of (inflight_valid[b] & inflight_req[b]==i & ~flush).
  - reg_read_resp_data[i] = prf_read_resp_data_by_bank[b] for the matching b, else 0.
  - At most one bank matches per requester, since a requester gets at most one grant per cycle.
- Latency: exactly 1 cycle from grant to response; throughput is 1 read per bank per cycle.
- flush:
  - Suppresses responses in the same cycle and clears all inflight_valid next cycle.
  - Grants in the flush cycle still happen and still advance rr_ptr, but their responses are dropped.
- Reset:
  - Asynchronous clear of all state.
  - All outputs are 0 while nRST=0, including combinational outputs, which are gated by nRST.
  - Reset mid-operation discards in-flight responses.
- Simultaneous events: multiple banks grant independently in the same cycle. A bank going not-ready blocks only that bank.

Test Plan:
- Single request: req0 valid, bank 2, pr 0x15 → same cycle prf_read_valid[2]=1, pr=0x15, ready[0]=1; next cycle with data_by_bank[2]=0xDEADBEEF → resp_valid[0]=1, data=0xDEADBEEF; all other resp_valid=0.
- Round-robin fairness:
  - All 4 requesters hold requests to bank 1, rr_ptr=0 → grants 0,1,2,3,0 on consecutive cycles.
  - rr_ptr[1] ends at 1.
  - Responses track grants with 1-cycle lag.
- Parallel banks: req0→bank0, req1→bank1, req2→bank2, req3→bank3 in one cycle → all four ready=1; next cycle all four resp_valid=1 with their own bank data.
- Bank stall: prf_read_ready[3]=0 for 3 cycles with req2 on bank 3 → no grant, rr_ptr[3] unchanged; ready rises → grant req2, response next cycle.
- Flush: grant req1 on bank0 at T, flush=1 at T+1 → resp_valid[1]=0 at T+1; flush in grant cycle → no response at T+1.
- Reset mid-op: assert nRST=0 with inflight_valid set → all outputs 0 immediately; after release rr_ptr=0 and first grant goes to lowest requester.
